// File: rtl/btn_event_decoder_if.sv
// Button event bus: debounced level and sample tick in, event strobes,
// hold level and wrapping event count out.
interface btn_event_decoder_if #(
  parameter int CNT_W = 8
);
  logic             i_pulsein;
  logic             i_db;
  logic             o_press;
  logic             o_release;
  logic             o_longpress;
  logic             o_rpt;
  logic             o_held;
  logic [CNT_W-1:0] o_evcount;

  // Producer side: drives the button level and tick, watches the events.
  modport master (
    output i_pulsein, i_db,
    input  o_press, o_release, o_longpress, o_rpt, o_held, o_evcount
  );

  // Decoder side: consumes the button level and tick, produces the events.
  modport slave (
    input  i_pulsein, i_db,
    output o_press, o_release, o_longpress, o_rpt, o_held, o_evcount
  );
endinterface

// File: rtl/btn_event_decoder.sv
// Button event decoder: turns the debounced button level into single-cycle
// press / release / long-press / auto-repeat strobes plus a wrapping count
// of press and repeat events. All outputs are registered.
module btn_event_decoder #(
  parameter int HOLD_TICKS   = 100,
  parameter int REPEAT_TICKS = 20,
  parameter int CNT_W        = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  btn_event_decoder_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_t;

  // Terminal counts; the tick that reaches these is the HOLD/REPEAT-th tick.
  localparam logic [15:0] HOLD_LAST   = 16'(HOLD_TICKS - 1);
  localparam logic [15:0] REPEAT_LAST = 16'(REPEAT_TICKS - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic             r_dbQ;
  logic [15:0]      r_hcnt;
  logic [15:0]      r_rcnt;
  logic [15:0]      w_hcntNext;
  logic [15:0]      w_rcntNext;
  logic             w_rise;
  logic             w_fall;
  logic             w_press;
  logic             w_release;
  logic             w_longpress;
  logic             w_rpt;
  logic             r_press;
  logic             r_release;
  logic             r_longpress;
  logic             r_rpt;
  logic             r_held;
  logic [CNT_W-1:0] r_evcount;

  assign w_rise = bus.i_db & ~r_dbQ;
  assign w_fall = ~bus.i_db & r_dbQ;

  // Next state, counter updates and strobe decisions; a falling edge always
  // wins over a tick so a release never comes with a long-press or repeat.
  always_comb begin
    w_nextState = r_state;
    w_hcntNext  = r_hcnt;
    w_rcntNext  = r_rcnt;
    w_press     = 1'b0;
    w_release   = 1'b0;
    w_longpress = 1'b0;
    w_rpt       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_nextState = PRESSED;
          w_press     = 1'b1;
          w_hcntNext  = 16'd0;
        end
      end
      PRESSED: begin
        if (w_fall) begin
          w_nextState = IDLE;
          w_release   = 1'b1;
        end else if (bus.i_pulsein) begin
          if (r_hcnt == HOLD_LAST) begin
            w_nextState = LONG;
            w_longpress = 1'b1;
            w_rcntNext  = 16'd0;
          end else begin
            w_hcntNext = r_hcnt + 16'd1;
          end
        end
      end
      LONG: begin
        if (w_fall) begin
          w_nextState = IDLE;
          w_release   = 1'b1;
        end else if (bus.i_pulsein) begin
          if (r_rcnt == REPEAT_LAST) begin
            w_rpt      = 1'b1;
            w_rcntNext = 16'd0;
          end else begin
            w_rcntNext = r_rcnt + 16'd1;
          end
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State, edge-detect history, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_dbQ       <= 1'b0;
      r_hcnt      <= 16'd0;
      r_rcnt      <= 16'd0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_longpress <= 1'b0;
      r_rpt       <= 1'b0;
      r_held      <= 1'b0;
      r_evcount   <= '0;
    end else begin
      r_state     <= w_nextState;
      r_dbQ       <= bus.i_db;
      r_hcnt      <= w_hcntNext;
      r_rcnt      <= w_rcntNext;
      r_press     <= w_press;
      r_release   <= w_release;
      r_longpress <= w_longpress;
      r_rpt       <= w_rpt;
      r_held      <= (w_nextState != IDLE);
      if (w_press | w_rpt) begin
        r_evcount <= r_evcount + CNT_W'(1);
      end
    end
  end

  assign bus.o_press     = r_press;
  assign bus.o_release   = r_release;
  assign bus.o_longpress = r_longpress;
  assign bus.o_rpt       = r_rpt;
  assign bus.o_held      = r_held;
  assign bus.o_evcount   = r_evcount;

endmodule

// File: doc/btn_event_decoder.md
# btn_event_decoder

Receiving end of the debounced-button path: consumes the clean `db` level from the shift-register debouncer plus the same `pulsein` sample tick, and converts it into single-cycle button events. It produces press, release, long-press and auto-repeat strobes and a wrapping event count that feeds the segment-load / counter logic. Pure control block: one clock, all outputs registered.

## Interface
- `HOLD_TICKS`, 100: `pulsein` ticks a press must be held before `longpress` fires (1 s at a 10 ms tick); legal range 1..65535.
- `REPEAT_TICKS`, 20: `pulsein` ticks between `rpt` strobes once in long-press; legal range 1..65535.
- `CNT_W`, 8: width of `evcount`.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high; clears all state on a rising `clk` edge where it is 1.
- `pulsein`  in  1  one-`clk`-wide sample tick from the shared tick generator.
- `db`  in  1  debounced button level, 1 = pressed; already synchronous to `clk`.
- `press`  out  1  one-cycle strobe on a press.
- `release`  out  1  one-cycle strobe on a release.
- `longpress`  out  1  one-cycle strobe when the hold time elapses.
- `rpt`  out  1  one-cycle auto-repeat strobe.
- `held`  out  1  level; 1 while the FSM is not in IDLE.
- `evcount`  out  CNT_W  count of `press` plus `rpt` events; wraps.

## Operation
- `db_q` holds `db` delayed by one clock.
  - `rise` = `db & ~db_q`.
  - `fall` = `~db & db_q`.
- Counters:
  - `hcnt` (16 b): hold counter.
  - `rcnt` (16 b): repeat counter.
- FSM states are IDLE, PRESSED and LONG.
- IDLE:
  - On `rise`: go to PRESSED, set `press`=1, clear `hcnt`.
  - `pulsein` is ignored in IDLE.
- PRESSED:
  - `fall` has priority: go to IDLE, set `release`=1.
  - Else on `pulsein`:
    - If `hcnt`==HOLD_TICKS-1: go to LONG, set `longpress`=1, clear `rcnt`.
    - Otherwise increment `hcnt`.
- LONG:
  - `fall` has priority: go to IDLE, set `release`=1.
  - Else on `pulsein`:
    - If `rcnt`==REPEAT_TICKS-1: set `rpt`=1, clear `rcnt`.
    - Otherwise increment `rcnt`.
- `held` = (next state != IDLE), registered. It rises together with `press` and falls together with `release`.
- `evcount` increments by 1 in the same edge that sets `press` or `rpt`, and wraps from 2^CNT_W-1 to 0. `press` and `rpt` are never set in the same cycle.
- Strobes default to 0 every cycle. Each strobe is high for exactly one `clk` cycle.

## Timing
- Reset values: state IDLE, `db_q`=0, `hcnt`=`rcnt`=0, every output 0 including `evcount`.
- Latency: `db` first sampled 1 at edge N means `press`, `held` and the `evcount` update are visible from edge N. The same rule applies to `release` on a falling `db`.
- The `pulsein` tick in the same cycle as `rise` is not counted. `longpress` therefore fires at the edge of the HOLD_TICKS-th `pulsein` after the press edge.
- First `rpt` fires REPEAT_TICKS ticks after `longpress`. Subsequent `rpt` strobes are spaced every REPEAT_TICKS ticks.
- If `fall` and a terminal `pulsein` occur in the same cycle, only `release` fires. No `longpress` or `rpt` is generated and there is no `evcount` change.
- With HOLD_TICKS=1, `longpress` fires on the first tick after the press edge, never in the same cycle as `press`.
- Reset mid-operation (any state) returns everything to reset values; no `release` is generated.
  - Because `db_q` resets to 0, a button still held when reset deasserts produces `press` at the first edge after reset.
- `db` pulses one clock wide still produce one `press` and one `release`. The debouncer upstream prevents these; they are not filtered here.

## Test plan
- Reset with `db`=0, then 10 idle cycles -> all outputs 0, `evcount`=0; `pulsein` toggling causes no strobes.
- HOLD_TICKS=4, `pulsein` every 5 clk, `db` high for 12 clk -> one `press` on the rise edge, `held` high for 12 cycles, one `release`, no `longpress`, `evcount`=1.
- HOLD_TICKS=4, REPEAT_TICKS=2, `pulsein` every 5 clk, `db` held for 40 clk -> `press` at t0; `longpress` at the 4th tick; `rpt` at the 6th tick; tick 7 produces no strobe; final `evcount`=3; single `release`.
- Same parameters, `db` falls in the exact cycle of the 4th `pulsein` -> `release` only, no `longpress`, `evcount`=1.
- CNT_W=3, eight short presses -> `evcount` goes 1..7 then wraps to 0.
- Assert `reset` for one cycle while in LONG with `db` still 1 -> outputs 0 at that edge, no `release`; `press` at the next edge; `evcount`=1.
